// File: rtl/field_extractor.sv
// Captures one field (even rows, or odd rows when FIELD_SEL_EN is defined) of a progressive
// frame into an internal buffer and serves it in raster order to the ELA stage via req/in_data.
module field_extractor #(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 32,
    parameter int unsigned DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic          s_sof,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    input  logic          req,
    output logic [DW-1:0] in_data,
    output logic          field_rdy,
    output logic          err,
    output logic          busy
`ifdef FIELD_SEL_EN
    ,
    input  logic          field_sel
`endif
);

    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned DEPTH = (ROWS / 2) * COLS;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            err_q, err_d;
    logic            field_rdy_q;
    logic            busy_q;
    logic            acc;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            sof_field;
    logic            cur_field;
    logic [DW-1:0]   mem [DEPTH];

    // Field parity: taken from field_sel on the accepted sof pixel, then held for the frame.
`ifdef FIELD_SEL_EN
    logic field_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_q <= 1'b0;
        end else if (acc && s_sof) begin
            field_q <= field_sel;
        end
    end

    assign sof_field = field_sel;
    assign cur_field = field_q;
`else
    assign sof_field = 1'b0;
    assign cur_field = 1'b0;
`endif

    assign s_ready   = ~rst & ((state_q == IDLE) || (state_q == CAPT));
    assign acc       = s_valid & s_ready;
    assign in_data   = ((state_q == FULL) || (state_q == DRAIN)) ? mem[rd_ptr_q] : '0;
    assign field_rdy = field_rdy_q;
    assign err       = err_q;
    assign busy      = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            field_rdy_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            field_rdy_q <= (state_d == FULL) || (state_d == DRAIN);
            busy_q      <= (state_d == CAPT) || (state_d == DRAIN);
        end
    end

    // Field buffer; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= s_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        wr_addr  = {row_q[RW-1:1], col_q};

        case (state_q)
            IDLE: begin
                if (req) begin
                    err_d = 1'b1;
                end
                // Pixels before the first sof are dropped silently.
                if (acc && s_sof) begin
                    wr_en   = ~sof_field;
                    wr_addr = '0;
                    col_d   = CW'(1);
                    row_d   = '0;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (req) begin
                    err_d = 1'b1;
                end
                if (acc) begin
                    if (s_sof) begin
                        // Mid-frame sof restarts at (0,0) and overwrites the partial field.
                        wr_en   = ~sof_field;
                        wr_addr = '0;
                        col_d   = CW'(1);
                        row_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        wr_en = (row_q[0] == cur_field);
                        col_d = CW'(col_q + 1'b1);
                        if (col_q == CW'(COLS - 1)) begin
                            row_d = RW'(row_q + 1'b1);
                            if (row_q == RW'(ROWS - 1)) begin
                                rd_ptr_d = '0;
                                state_d  = FULL;
                            end
                        end
                    end
                end
            end
            FULL: begin
                if (req) begin
                    rd_ptr_d = AW'(rd_ptr_q + 1'b1);
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (req) begin
                    rd_ptr_d = AW'(rd_ptr_q + 1'b1);
                    if (rd_ptr_q == AW'(DEPTH - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_field_extractor.sv
// Self-checking bench for field_extractor: table of frame scenarios with a pixel scoreboard,
// plus hand-written underflow, reset and (with FIELD_SEL_EN) odd-field sequences.
module tb_field_extractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_sof;
    logic [7:0] s_data;
    logic       s_ready;
    logic       req;
    logic [7:0] in_data;
    logic       field_rdy;
    logic       err;
    logic       busy;
`ifdef FIELD_SEL_EN
    logic       field_sel;
`endif

    field_extractor dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_sof     (s_sof),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .req       (req),
        .in_data   (in_data),
        .field_rdy (field_rdy),
        .err       (err),
        .busy      (busy)
`ifdef FIELD_SEL_EN
        ,
        .field_sel (field_sel)
`endif
    );

    always #5 clk = ~clk;

    int         errs   = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         kept_field = 0;

    typedef struct {
        int   junk;
        int   vmode;
        int   rmode;
        int   abort_at;
        logic exp_err;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = 8'h00; req = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_field_rdy", {31'd0, field_rdy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_data", {24'd0, in_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    endtask

    // Drives pixels [start, start+count) of a frame; p = index, or a constant when cfix.
    task automatic drive_pixels(input int start, input int count, input int vmode,
                                input bit cfix, input logic [7:0] cval, input bit push);
        int p = start;
        int n = 0;
        int guard = 0;
        bit phase = 1'b0;
        while (n < count && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (vmode == 1 && phase) begin
                s_valid = 1'b0;
                s_sof   = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_sof   = (p == 0);
                s_data  = cfix ? cval : 8'(p & 255);
                if (p == 1023) chk("rdy_before_last", {31'd0, field_rdy}, 32'd0);
                if (s_ready) begin
                    if (push && ((p / 32) % 2) == kept_field) exp_q.push_back(s_data);
                    p++;
                    n++;
                end
            end
            phase = ~phase;
        end
        if (n < count) chk("drive_timeout", 32'(n), 32'(count));
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // Pops the scoreboard; rmode 0 holds req high, rmode 1 pulses 3 on / 2 off.
    task automatic drain(input int rmode, input logic exp_err);
        int k = 0;
        int guard = 0;
        logic on;
        logic [7:0] e;
        while (exp_q.size() > 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
            on = (rmode == 0) ? 1'b1 : ((k % 5) < 3);
            k++;
            req = on;
            #1;
            if (on) begin
                e = exp_q.pop_front();
                chk("pix", {24'd0, in_data}, {24'd0, e});
            end else begin
                chk("busy_hold", {31'd0, busy}, 32'd1);
            end
        end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("post_field_rdy", {31'd0, field_rdy}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_s_ready", {31'd0, s_ready}, 32'd1);
        chk("post_err", {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic check_full(input logic exp_err);
        #1;
        chk("full_field_rdy", {31'd0, field_rdy}, 32'd1);
        chk("full_busy", {31'd0, busy}, 32'd0);
        chk("full_s_ready", {31'd0, s_ready}, 32'd0);
        chk("full_err", {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = 8'h00; req = 1'b0;
`ifdef FIELD_SEL_EN
        field_sel = 1'b0;
`endif
        tbl[0] = '{junk: 0,  vmode: 0, rmode: 0, abort_at: 0,   exp_err: 1'b0};
        tbl[1] = '{junk: 0,  vmode: 1, rmode: 1, abort_at: 0,   exp_err: 1'b0};
        tbl[2] = '{junk: 10, vmode: 0, rmode: 0, abort_at: 0,   exp_err: 1'b0};
        tbl[3] = '{junk: 0,  vmode: 0, rmode: 1, abort_at: 300, exp_err: 1'b1};

        for (int i = 0; i < 4; i++) begin
            do_reset();
            for (int j = 0; j < tbl[i].junk; j++) begin
                @(negedge clk);
                s_valid = 1'b1; s_sof = 1'b0; s_data = 8'h77;
            end
            if (tbl[i].abort_at > 0) begin
                drive_pixels(0, tbl[i].abort_at, tbl[i].vmode, 1'b0, 8'h00, 1'b0);
                drive_pixels(0, 1024, tbl[i].vmode, 1'b1, 8'hA5, 1'b1);
            end else begin
                drive_pixels(0, 1024, tbl[i].vmode, 1'b0, 8'h00, 1'b1);
            end
            check_full(tbl[i].exp_err);
            drain(tbl[i].rmode, tbl[i].exp_err);
        end

        // Underflow while capturing: zero data, sticky err, capture unaffected.
        do_reset();
        drive_pixels(0, 40, 0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        req = 1'b1;
        #1;
        chk("capt_uf_data", {24'd0, in_data}, 32'd0);
        chk("capt_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("capt_uf_err", {31'd0, err}, 32'd1);
        drive_pixels(40, 984, 0, 1'b0, 8'h00, 1'b1);
        check_full(1'b1);
        drain(0, 1'b1);

        // Underflow in IDLE.
        do_reset();
        @(negedge clk);
        req = 1'b1;
        #1;
        chk("idle_uf_data", {24'd0, in_data}, 32'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("idle_uf_err", {31'd0, err}, 32'd1);
        chk("idle_uf_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        drive_pixels(0, 1024, 0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("mid_drain_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rdy", {31'd0, field_rdy}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_data", {24'd0, in_data}, 32'd0);
        exp_q.delete();

`ifdef FIELD_SEL_EN
        // Odd field selected at sof.
        do_reset();
        kept_field = 1;
        field_sel  = 1'b1;
        drive_pixels(0, 1024, 0, 1'b0, 8'h00, 1'b1);
        field_sel  = 1'b0;
        chk("odd_first", {24'd0, exp_q[0]}, 32'h20);
        chk("odd_last", {24'd0, exp_q[exp_q.size()-1]}, 32'hFF);
        check_full(1'b0);
        drain(0, 1'b0);
        kept_field = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
